// File: rtl/des_pkg.sv
// DES key-schedule constants, rotation helpers and scheduler state type.
// Shared by des_key_sched and des_pc2.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } sched_state_e;

  // PC-2 selection: 1-based positions into C||D, bit 1 = MSB, output bit 1 first
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:0] shift_of(input logic [3:0] idx);
    logic [1:0] amt;
    case (idx)
      4'd0, 4'd1, 4'd8, 4'd15: amt = 2'd1;
      default:                 amt = 2'd2;
    endcase
    return amt;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] r;
    case (amt)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] r;
    case (amt)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic is_weak(input logic [55:0] cd);
    logic c_flat;
    logic d_flat;
    c_flat = (cd[55:28] == 28'h0000000) | (cd[55:28] == 28'hFFFFFFF);
    d_flat = (cd[27:0]  == 28'h0000000) | (cd[27:0]  == 28'hFFFFFFF);
    return c_flat & d_flat;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 permutation: 56-bit C||D in, 48-bit round key out.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] round_key
);

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign round_key[47-i] = cd[56 - PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_sched.sv
// Streaming DES round-key sequencer: one PC-2 round key per handshake, forward or reverse order.
// Optional weak-key flag enabled by defining DES_KEY_SCHED_WEAK_CHK_EN.
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [55:0] sub_key_in,
  input  logic        sub_key_in_valid,
  output logic        sub_key_in_ready,
  input  logic        decrypt_in,
  output logic [47:0] round_key_out,
  output logic [3:0]  round_idx_out,
  output logic        round_key_valid_out,
  input  logic        round_key_ready_in,
  output logic        done_out,
  output logic        weak_key_out
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_EMIT = EMIT;

  logic [1:0]  state_r;
  logic [55:0] cd_r;
  logic [3:0]  idx_r;
  logic        dec_r;
  logic [47:0] key_r;
  logic        valid_r;
  logic        done_r;
  logic        ready_r;

  logic        accept_s;
  logic        emit_hs_s;
  logic [1:0]  shamt_s;
  logic [55:0] next_cd_s;
  logic [55:0] pc2_in_s;
  logic [47:0] pc2_out_s;

  assign accept_s  = sub_key_in_valid & ready_r;
  assign emit_hs_s = (state_r == ST_EMIT) & valid_r & round_key_ready_in;

  // Next C||D: encrypt looks ahead to the following round's left shift, decrypt undoes the current one
  always_comb begin
    shamt_s   = 2'd0;
    next_cd_s = cd_r;
    if (dec_r) begin
      shamt_s   = shift_of(4'd15 - idx_r);
      next_cd_s = {rotr28(cd_r[55:28], shamt_s), rotr28(cd_r[27:0], shamt_s)};
    end else begin
      shamt_s   = shift_of(idx_r + 4'd1);
      next_cd_s = {rotl28(cd_r[55:28], shamt_s), rotl28(cd_r[27:0], shamt_s)};
    end
  end

  // CALC presents the freshly loaded C||D; EMIT precomputes the key for the next handshake
  assign pc2_in_s = (state_r == ST_CALC) ? cd_r : next_cd_s;

  des_pc2 u_pc2 (
    .cd        (pc2_in_s),
    .round_key (pc2_out_s)
  );

  // Sequencer FSM and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
      cd_r    <= 56'h0;
      idx_r   <= 4'd0;
      dec_r   <= 1'b0;
      key_r   <= 48'h0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b1;
          if (accept_s) begin
            ready_r <= 1'b0;
            dec_r   <= decrypt_in;
            cd_r    <= decrypt_in ? sub_key_in :
                       {rotl28(sub_key_in[55:28], shift_of(4'd0)),
                        rotl28(sub_key_in[27:0],  shift_of(4'd0))};
            idx_r   <= 4'd0;
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          key_r   <= pc2_out_s;
          idx_r   <= 4'd0;
          valid_r <= 1'b1;
          state_r <= ST_EMIT;
        end
        ST_EMIT: begin
          if (emit_hs_s) begin
            if (idx_r == 4'd15) begin
              valid_r <= 1'b0;
              done_r  <= 1'b1;
              ready_r <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              idx_r <= idx_r + 4'd1;
              cd_r  <= next_cd_s;
              key_r <= pc2_out_s;
            end
          end
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sub_key_in_ready    = ready_r;
  assign round_key_out       = key_r;
  assign round_idx_out       = idx_r;
  assign round_key_valid_out = valid_r;
  assign done_out            = done_r;

`ifdef DES_KEY_SCHED_WEAK_CHK_EN
  logic weak_r;

  // Weak-key flag captured at accept and held until the next accept
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      weak_r <= 1'b0;
    end else if (accept_s) begin
      weak_r <= is_weak(sub_key_in);
    end
  end

  assign weak_key_out = weak_r;
`else
  assign weak_key_out = 1'b0;
`endif

endmodule
